// File: rtl/sample_writer.sv
// Packs pairs of samples into Wishbone words and writes them into a circular buffer in memory.
// A flush writes out a half-filled word; a retry causes a one-cycle pause before the identical write.
module sample_writer #(
    parameter int unsigned  DAT_WIDTH = 32,
    parameter int unsigned  ADR_WIDTH = 13,
    parameter int unsigned  SMP_WIDTH = 16,
    parameter int unsigned  BASE      = 0,
    parameter int unsigned  DEPTH     = 1024,
    localparam int unsigned PTR_WIDTH = $clog2(DEPTH)
) (
    input  logic                 clock,
    input  logic                 resetN,
    input  logic                 smpValid,
    input  logic [SMP_WIDTH-1:0] smpData,
    output logic                 smpReady,
    input  logic                 flush,
    output logic                 cyc_o,
    output logic                 stb_o,
    output logic                 we_o,
    output logic [ADR_WIDTH-1:0] adr_o,
    output logic [3:0]           sel_o,
    output logic [DAT_WIDTH-1:0] dat_o,
    input  logic                 ack_i,
    input  logic                 err_i,
    input  logic                 rty_i,
    output logic [PTR_WIDTH-1:0] wrPtr,
    output logic                 wrapped,
    output logic [7:0]           errCount
);

    // StRetry is the one idle cycle between a retried attempt and its re-issue.
    typedef enum logic [1:0] {StEmpty, StHalf, StBus, StRetry} state_t;

    state_t                 state_q, state_d;
    logic [DAT_WIDTH-1:0]   dat_q, dat_d;
    logic [3:0]             sel_q, sel_d;
    logic [PTR_WIDTH-1:0]   ptr_q, ptr_d;
    logic                   wrapped_q, wrapped_d;
    logic [7:0]             err_q, err_d;
    logic                   run_q;
    logic                   accept;

    // Holds smpReady low until the first clock edge after reset release.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            run_q <= 1'b0;
        end else begin
            run_q <= 1'b1;
        end
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state_q   <= StEmpty;
            dat_q     <= '0;
            sel_q     <= '0;
            ptr_q     <= '0;
            wrapped_q <= 1'b0;
            err_q     <= '0;
        end else begin
            state_q   <= state_d;
            dat_q     <= dat_d;
            sel_q     <= sel_d;
            ptr_q     <= ptr_d;
            wrapped_q <= wrapped_d;
            err_q     <= err_d;
        end
    end

    assign smpReady = run_q && (state_q == StEmpty || state_q == StHalf);
    assign accept   = smpValid && smpReady;

    always_comb begin
        state_d   = state_q;
        dat_d     = dat_q;
        sel_d     = sel_q;
        ptr_d     = ptr_q;
        wrapped_d = wrapped_q;
        err_d     = err_q;

        unique case (state_q)
            StEmpty: begin
                if (accept) begin
                    dat_d[SMP_WIDTH-1:0] = smpData;
                    state_d              = StHalf;
                end
            end
            StHalf: begin
                // A sample arriving with flush completes the word; the flush is dropped.
                if (accept) begin
                    dat_d[DAT_WIDTH-1:SMP_WIDTH] = smpData;
                    sel_d                        = 4'b1111;
                    state_d                      = StBus;
                end else if (flush) begin
                    sel_d   = 4'b0011;
                    state_d = StBus;
                end
            end
            StBus: begin
                if (ack_i) begin
                    if (ptr_q == PTR_WIDTH'(DEPTH - 1)) begin
                        ptr_d     = '0;
                        wrapped_d = 1'b1;
                    end else begin
                        ptr_d = ptr_q + PTR_WIDTH'(1);
                    end
                    state_d = StEmpty;
                end else if (err_i) begin
                    if (err_q != 8'hff) begin
                        err_d = err_q + 8'd1;
                    end
                    state_d = StEmpty;
                end else if (rty_i) begin
                    state_d = StRetry;
                end
            end
            StRetry: begin
                state_d = StBus;
            end
            default: begin
                state_d = StEmpty;
            end
        endcase
    end

    assign cyc_o    = (state_q == StBus);
    assign stb_o    = (state_q == StBus);
    assign we_o     = (state_q == StBus);
    assign adr_o    = ADR_WIDTH'(BASE) + (ADR_WIDTH'(ptr_q) << 2);
    assign sel_o    = sel_q;
    assign dat_o    = dat_q;
    assign wrPtr    = ptr_q;
    assign wrapped  = wrapped_q;
    assign errCount = err_q;

endmodule

// File: tb/tb_sample_writer.sv
// Bench for sample_writer: directed vector table, multi-cycle corner sequences and a
// randomized run checked against a word-level reference model.
module tb_sample_writer;

    localparam int unsigned DW    = 32;
    localparam int unsigned AW    = 13;
    localparam int unsigned SW    = 16;
    localparam int unsigned BASE  = 0;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned PW    = 2;

    logic          clock = 1'b0;
    logic          resetN = 1'b1;
    logic          smpValid = 1'b0;
    logic [SW-1:0] smpData = '0;
    logic          flush = 1'b0;
    logic          smpReady;
    logic          cyc_o, stb_o, we_o;
    logic [AW-1:0] adr_o;
    logic [3:0]    sel_o;
    logic [DW-1:0] dat_o;
    logic          ack_i, err_i, rty_i;
    logic [PW-1:0] wrPtr;
    logic          wrapped;
    logic [7:0]    errCount;

    // Slave model: responses are gated by the strobe, so they act combinationally.
    logic a_r = 1'b0, e_r = 1'b0, r_r = 1'b0;
    assign ack_i = cyc_o & stb_o & a_r;
    assign err_i = cyc_o & stb_o & e_r;
    assign rty_i = cyc_o & stb_o & r_r;

    int errors = 0;
    int checks = 0;

    sample_writer #(
        .DAT_WIDTH(DW), .ADR_WIDTH(AW), .SMP_WIDTH(SW), .BASE(BASE), .DEPTH(DEPTH)
    ) dut (
        .clock(clock), .resetN(resetN), .smpValid(smpValid), .smpData(smpData),
        .smpReady(smpReady), .flush(flush), .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o),
        .adr_o(adr_o), .sel_o(sel_o), .dat_o(dat_o), .ack_i(ack_i), .err_i(err_i),
        .rty_i(rty_i), .wrPtr(wrPtr), .wrapped(wrapped), .errCount(errCount)
    );

    always #5 clock = ~clock;

    logic [AW-1:0] acked[$];
    always @(negedge clock) begin
        if (cyc_o && stb_o && ack_i) acked.push_back(adr_o);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        @(negedge clock);
        resetN = 1'b0; smpValid = 1'b0; flush = 1'b0; a_r = 1'b0; e_r = 1'b0; r_r = 1'b0;
        #2;
        chk("rst cyc", {31'd0, cyc_o}, 0);
        chk("rst stb_we", {30'd0, stb_o, we_o}, 0);
        chk("rst ready", {31'd0, smpReady}, 0);
        chk("rst sel", {28'd0, sel_o}, 0);
        chk("rst dat", dat_o, 0);
        chk("rst adr", {19'd0, adr_o}, BASE);
        chk("rst ptr_wrap_err", {21'd0, wrPtr, wrapped, errCount}, 0);
        @(negedge clock);
        resetN = 1'b1;
        #1 chk("ready before first edge", {31'd0, smpReady}, 0);
    endtask

    // Call just after a negedge; returns at the negedge following the accepting edge.
    task automatic send(input logic [SW-1:0] d);
        bit done = 0;
        smpValid = 1'b1;
        smpData  = d;
        for (int i = 0; i < 50 && !done; i++) begin
            if (smpReady) done = 1;
            @(negedge clock);
        end
        smpValid = 1'b0;
        if (!done) chk("send timeout", 0, 1);
    endtask

    typedef struct {
        logic          v;
        logic [SW-1:0] d;
        logic          fl, a, e, r;
        logic          er, ec;
        logic [3:0]    esel;
        logic [AW-1:0] eadr;
        logic [DW-1:0] edat;
        logic [PW-1:0] eptr;
        logic          ewr;
        logic [7:0]    eerr;
    } vec_t;
    vec_t tbl[$];

    task automatic row(input logic v, input logic [15:0] d, input logic fl, input logic a,
                       input logic e, input logic r, input logic er, input logic ec,
                       input logic [3:0] esel, input logic [12:0] eadr, input logic [31:0] edat,
                       input logic [1:0] eptr, input logic ewr, input logic [7:0] eerr);
        vec_t t;
        t.v = v; t.d = d; t.fl = fl; t.a = a; t.e = e; t.r = r; t.er = er; t.ec = ec;
        t.esel = esel; t.eadr = eadr; t.edat = edat; t.eptr = eptr; t.ewr = ewr; t.eerr = eerr;
        tbl.push_back(t);
    endtask

    // Reference model: held samples, the pending word and the ring bookkeeping.
    int            m_nh;
    logic [SW-1:0] m_lo;
    bit            m_have, m_gap;
    logic [DW-1:0] m_word;
    logic [3:0]    m_sel;
    int            m_ptr, m_errc;
    bit            m_wr;

    initial begin
        logic [31:0] mask;
        int x;

        // v d fl a e r | ready cyc sel adr dat ptr wrapped errCount
        row(1, 16'h1111, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        row(1, 16'h2222, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        row(0, 16'h0000, 0, 1, 0, 0, 0, 1, 4'hf, 13'h000, 32'h22221111, 0, 0, 0);
        row(1, 16'haaaa, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0);
        row(0, 16'h0000, 1, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0);
        row(0, 16'h0000, 0, 1, 0, 0, 0, 1, 4'h3, 13'h004, 32'h0000aaaa, 1, 0, 0);
        row(0, 16'h0000, 0, 0, 0, 0, 1, 0, 0, 0, 0, 2, 0, 0);
        row(0, 16'h0000, 1, 0, 0, 0, 1, 0, 0, 0, 0, 2, 0, 0);
        row(0, 16'h0000, 0, 0, 0, 0, 1, 0, 0, 0, 0, 2, 0, 0);
        row(1, 16'hbbbb, 0, 0, 0, 0, 1, 0, 0, 0, 0, 2, 0, 0);
        row(1, 16'hcccc, 1, 0, 0, 0, 1, 0, 0, 0, 0, 2, 0, 0);
        row(0, 16'h0000, 0, 1, 0, 0, 0, 1, 4'hf, 13'h008, 32'hccccbbbb, 2, 0, 0);
        row(1, 16'h1234, 0, 0, 0, 0, 1, 0, 0, 0, 0, 3, 0, 0);
        row(1, 16'h5678, 0, 0, 0, 0, 1, 0, 0, 0, 0, 3, 0, 0);
        row(0, 16'h0000, 0, 0, 1, 0, 0, 1, 4'hf, 13'h00c, 32'h56781234, 3, 0, 0);
        row(1, 16'h5555, 0, 0, 0, 0, 1, 0, 0, 0, 0, 3, 0, 1);
        row(1, 16'h6666, 0, 0, 0, 0, 1, 0, 0, 0, 0, 3, 0, 1);
        row(0, 16'h0000, 0, 0, 0, 1, 0, 1, 4'hf, 13'h00c, 32'h66665555, 3, 0, 1);
        row(0, 16'h0000, 0, 1, 0, 0, 0, 0, 0, 0, 0, 3, 0, 1);
        row(0, 16'h0000, 0, 1, 0, 0, 0, 1, 4'hf, 13'h00c, 32'h66665555, 3, 0, 1);
        row(1, 16'h0001, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 1);
        row(1, 16'h0002, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 1);
        row(0, 16'h0000, 0, 1, 1, 1, 0, 1, 4'hf, 13'h000, 32'h00020001, 0, 1, 1);
        row(1, 16'h0003, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 1, 1);
        row(1, 16'h0004, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 1, 1);
        row(0, 16'h0000, 0, 0, 1, 1, 0, 1, 4'hf, 13'h004, 32'h00040003, 1, 1, 1);
        row(0, 16'h0000, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 1, 2);

        do_reset();
        foreach (tbl[i]) begin
            @(negedge clock);
            chk($sformatf("r%0d ready", i), {31'd0, smpReady}, {31'd0, tbl[i].er});
            chk($sformatf("r%0d cyc_stb_we", i), {29'd0, cyc_o, stb_o, we_o},
                {29'd0, {3{tbl[i].ec}}});
            chk($sformatf("r%0d ptr", i), {30'd0, wrPtr}, {30'd0, tbl[i].eptr});
            chk($sformatf("r%0d wrapped", i), {31'd0, wrapped}, {31'd0, tbl[i].ewr});
            chk($sformatf("r%0d errCount", i), {24'd0, errCount}, {24'd0, tbl[i].eerr});
            if (tbl[i].ec) begin
                mask = (tbl[i].esel == 4'hf) ? 32'hffff_ffff : 32'h0000_ffff;
                chk($sformatf("r%0d adr", i), {19'd0, adr_o}, {19'd0, tbl[i].eadr});
                chk($sformatf("r%0d sel", i), {28'd0, sel_o}, {28'd0, tbl[i].esel});
                chk($sformatf("r%0d dat", i), dat_o & mask, tbl[i].edat & mask);
            end
            smpValid = tbl[i].v; smpData = tbl[i].d; flush = tbl[i].fl;
            a_r = tbl[i].a; e_r = tbl[i].e; r_r = tbl[i].r;
        end
        @(negedge clock);
        smpValid = 1'b0; flush = 1'b0; a_r = 1'b0; e_r = 1'b0; r_r = 1'b0;

        // Ring wrap over ten samples with an always-acking slave.
        do_reset();
        acked.delete();
        a_r = 1'b1;
        for (int i = 0; i < 8; i++) send(16'(i));
        chk("wrap cyc before 4th ack", {31'd0, cyc_o}, 1);
        chk("wrap before 4th ack", {31'd0, wrapped}, 0);
        @(negedge clock);
        chk("wrap after 4th ack", {31'd0, wrapped}, 1);
        chk("ptr after 4th ack", {30'd0, wrPtr}, 0);
        send(16'h0008);
        send(16'h0009);
        @(negedge clock);
        #1;
        chk("wrap final ptr", {30'd0, wrPtr}, 1);
        chk("wrap write count", acked.size(), 5);
        for (int i = 0; i < 5 && i < acked.size(); i++)
            chk($sformatf("wrap adr%0d", i), {19'd0, acked[i]}, BASE + 4 * (i % DEPTH));

        // Error responses: single drop, then saturation.
        do_reset();
        e_r = 1'b1;
        send(16'h0101);
        send(16'h0202);
        @(negedge clock);
        chk("err count one", {24'd0, errCount}, 1);
        chk("err ptr unchanged", {30'd0, wrPtr}, 0);
        for (int i = 0; i < 299; i++) begin
            send(16'(i));
            send(16'(i + 1));
        end
        @(negedge clock);
        chk("err saturated", {24'd0, errCount}, 255);
        chk("err ptr still 0", {30'd0, wrPtr}, 0);
        e_r = 1'b0;

        // Reset asserted while a write is stalled on the bus.
        do_reset();
        a_r = 1'b1;
        send(16'h0011);
        send(16'h0022);
        @(negedge clock);
        a_r = 1'b0;
        send(16'h0033);
        send(16'h0044);
        chk("midbus cyc high", {31'd0, cyc_o}, 1);
        chk("midbus adr", {19'd0, adr_o}, BASE + 4);
        #2 resetN = 1'b0;
        #1 chk("async reset cyc", {30'd0, cyc_o, stb_o}, 0);
        @(negedge clock);
        resetN = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            chk($sformatf("no retry after reset %0d", i), {31'd0, cyc_o}, 0);
        end
        a_r = 1'b1;
        send(16'h0055);
        send(16'h0066);
        chk("post reset cyc", {31'd0, cyc_o}, 1);
        chk("post reset adr", {19'd0, adr_o}, BASE);
        @(negedge clock);

        // Randomized run against the reference model.
        do_reset();
        m_nh = 0; m_lo = '0; m_have = 0; m_gap = 0; m_word = '0; m_sel = '0;
        m_ptr = 0; m_errc = 0; m_wr = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clock);
            chk("rnd ready", {31'd0, smpReady}, {31'd0, !m_have});
            chk("rnd cyc", {31'd0, cyc_o}, {31'd0, m_have && !m_gap});
            chk("rnd ptr", {30'd0, wrPtr}, m_ptr);
            chk("rnd wrapped_err", {23'd0, wrapped, errCount}, {23'd0, m_wr, 8'(m_errc)});
            if (m_have && !m_gap) begin
                mask = (m_sel == 4'hf) ? 32'hffff_ffff : 32'h0000_ffff;
                chk("rnd adr", {19'd0, adr_o}, (BASE + 4 * m_ptr) % (1 << AW));
                chk("rnd sel", {28'd0, sel_o}, {28'd0, m_sel});
                chk("rnd dat", dat_o & mask, m_word & mask);
            end
            smpValid = ($urandom_range(0, 3) != 0);
            smpData  = 16'($urandom);
            flush    = ($urandom_range(0, 4) == 0);
            x        = $urandom_range(0, 7);
            a_r = (x < 4) || (x == 7);
            e_r = (x == 4) || (x == 7);
            r_r = (x == 5) || (x == 7);
            if (m_have && !m_gap) begin
                if (a_r) begin
                    m_ptr = (m_ptr + 1) % DEPTH;
                    if (m_ptr == 0) m_wr = 1;
                    m_have = 0;
                end else if (e_r) begin
                    if (m_errc < 255) m_errc++;
                    m_have = 0;
                end else if (r_r) begin
                    m_gap = 1;
                end
            end else if (m_gap) begin
                m_gap = 0;
            end else if (smpValid) begin
                if (m_nh == 0) begin
                    m_lo = smpData; m_nh = 1;
                end else begin
                    m_word = {smpData, m_lo}; m_sel = 4'hf; m_have = 1; m_nh = 0;
                end
            end else if (flush && m_nh == 1) begin
                m_word = {16'h0000, m_lo}; m_sel = 4'h3; m_have = 1; m_nh = 0;
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sample_writer.md
SAMPLE_WRITER -- requirements
Module: sample_writer

Interface
REQ-001 SHALL have parameter DAT_WIDTH, default 32: Wishbone data width, two samples per word.
REQ-002 SHALL have parameter ADR_WIDTH, default 13: Wishbone byte-address width.
REQ-003 SHALL have parameter SMP_WIDTH, default 16: sample width; equals DAT_WIDTH/2.
REQ-004 SHALL have parameter BASE, default 0: byte address of ring start; word-aligned.
REQ-005 SHALL have parameter DEPTH, default 1024: ring length in words; at least 2.
REQ-006 SHALL have port clock, input, 1: the single clock; all state updates on its rising edge.
REQ-007 SHALL have port resetN, input, 1: asynchronous, active-low reset.
REQ-008 SHALL have port smpValid, input, 1: a sample is offered.
REQ-009 SHALL have port smpData, input, SMP_WIDTH: sample value.
REQ-010 SHALL have port smpReady, output, 1: a sample is accepted when smpValid and smpReady are both high.
REQ-011 SHALL have port flush, input, 1: single-cycle pulse; write out any half-filled word.
REQ-012 SHALL have ports cyc_o, stb_o and we_o, each output, 1: Wishbone master cycle, strobe and write-enable.
REQ-013 SHALL have port adr_o, output, ADR_WIDTH: Wishbone byte address.
REQ-014 SHALL have port sel_o, output, 4: byte selects.
REQ-015 SHALL have port dat_o, output, DAT_WIDTH: write data.
REQ-016 SHALL have ports ack_i, err_i and rty_i, each input, 1: Wishbone slave termination signals.
REQ-017 SHALL have port wrPtr, output, log2(DEPTH): index of the next ring word to be written.
REQ-018 SHALL have port wrapped, output, 1: sticky flag, set once the ring has wrapped.
REQ-019 SHALL have port errCount, output, 8: count of words dropped on err_i; saturates at 255.

Function
REQ-020 SHALL implement three states: EMPTY (no sample held), HALF (low half held), BUS (Wishbone write in progress).
REQ-021 SHALL drive smpReady high in EMPTY and HALF, and low in BUS.
REQ-022 SHALL, on an accepted sample in EMPTY, latch it into dat_o[SMP_WIDTH-1:0] and go to HALF.
REQ-023 SHALL, on an accepted sample in HALF, latch it into the upper half, set sel_o=4'b1111 and go to BUS; cyc_o/stb_o are high the next cycle.
REQ-024 SHALL, on flush in HALF with no accepted sample that cycle, set sel_o=4'b0011 and go to BUS.
REQ-025 SHALL ignore flush in EMPTY and BUS.
REQ-026 SHALL, when flush and an accepted sample coincide in HALF, complete the full word (sel 4'b1111) and discard the flush.
REQ-027 SHALL drive cyc_o, stb_o and we_o high throughout BUS, and low in all other states.
REQ-028 SHALL hold adr_o, sel_o and dat_o stable throughout BUS.
REQ-029 SHALL drive adr_o = BASE + 4*wrPtr, truncated to ADR_WIDTH.
REQ-030 SHALL, on ack_i in BUS, advance wrPtr by 1, wrapping from DEPTH-1 to 0; set wrapped on that wrap; return to EMPTY.
REQ-031 SHALL, on err_i in BUS (ack_i low), drop the word, leave wrPtr unchanged, increment errCount with saturation and return to EMPTY.
REQ-032 SHALL, on rty_i in BUS (ack_i and err_i low), deassert cyc_o/stb_o for exactly one cycle, then re-issue the identical write.
REQ-033 SHALL give priority ack_i > err_i > rty_i when more than one is high.
REQ-034 SHALL, with a slave that acks combinationally, keep smpReady low for exactly one cycle per word (the BUS cycle).
REQ-035 SHALL leave the upper half of dat_o unspecified after a flush write; only sel_o is normative.

Reset
REQ-036 SHALL, while resetN is low (immediately, without waiting for clock), set state EMPTY; cyc_o, stb_o and we_o 0; smpReady 0; sel_o 0; dat_o 0; adr_o BASE; wrPtr 0; wrapped 0; errCount 0.
REQ-037 SHALL drive smpReady high from the first rising edge after resetN deasserts.
REQ-038 SHALL abandon any write in flight when reset is asserted mid-BUS, with no retry after release.

Verification
REQ-039 SHALL check: samples 0x1111 then 0x2222, ack_i tied to cyc&stb -> one write, adr 0x000, dat 0x22221111, sel 1111; wrPtr becomes 1.
REQ-040 SHALL check: sample 0xAAAA then flush -> write with sel 0011, dat[15:0] 0xAAAA; state returns to EMPTY.
REQ-041 SHALL check: DEPTH=4, 10 samples -> addresses 0x0,0x4,0x8,0xC,0x0; wrapped set on the 4th ack; wrPtr=1.
REQ-042 SHALL check: rty_i on the first attempt and ack_i on the second -> identical adr/dat/sel both times, with exactly one idle cycle between them.
REQ-043 SHALL check: err_i response -> errCount=1, wrPtr unchanged; 300 error responses -> errCount=255.
REQ-044 SHALL check: resetN low mid-BUS -> cyc_o low asynchronously; after release the first write uses adr BASE.
